// File: rtl/uart_tx_fifo.sv
// Transmit FIFO feeding a UART transmitter: buffers host bytes and hands them out one frame at a time.
// Optional sticky overflow flag is built when UART_TX_FIFO_OVF_EN is defined.
module uart_tx_fifo #(
  parameter int unsigned DEPTH_BITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic [7:0]            wr_data,
  input  logic                  wr_en,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_BITS:0]   count,
  output logic                  overflow,
  input  logic                  clr_ovf,
  input  logic                  tx_busy,
  output logic [7:0]            tx_data,
  output logic                  tx_start
);

  localparam logic [DEPTH_BITS:0]   CountFull = {1'b1, {DEPTH_BITS{1'b0}}};
  localparam logic [DEPTH_BITS:0]   CountOne  = 1;
  localparam logic [DEPTH_BITS-1:0] PtrOne    = 1;

  typedef enum logic [1:0] {StIdle, StStart, StSend} state_e;

  logic [7:0]            mem [2**DEPTH_BITS];
  logic [DEPTH_BITS-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_BITS:0]   count_q;
  logic [7:0]            tx_data_q;
  state_e                state_q, state_d;
  logic                  push, pop;

  assign full  = (count_q == CountFull);
  assign empty = (count_q == '0);
  assign count = count_q;
  assign tx_data  = tx_data_q;
  assign tx_start = (state_q == StStart);

  // Drop decisions use the pre-edge count, so a same-cycle pop never rescues a write to a full FIFO.
  assign push = wr_en && !full;

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (ena && !empty && !tx_busy) begin
          pop     = 1'b1;
          state_d = StStart;
        end
      end
      StStart: if (tx_busy) state_d = StSend;
      StSend:  if (!tx_busy) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      tx_data_q <= 8'h00;
    end else begin
      state_q <= state_d;
      if (push) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (pop) begin
        rd_ptr_q  <= rd_ptr_q + PtrOne;
        tx_data_q <= mem[rd_ptr_q];
      end
      if (push && !pop)      count_q <= count_q + CountOne;
      else if (pop && !push) count_q <= count_q - CountOne;
    end
  end

`ifdef UART_TX_FIFO_OVF_EN
  logic overflow_q;

  // A drop in the same cycle as a clear leaves the flag set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow_q <= 1'b0;
    end else if (wr_en && full) begin
      overflow_q <= 1'b1;
    end else if (clr_ovf) begin
      overflow_q <= 1'b0;
    end
  end

  assign overflow = overflow_q;
`else
  logic clr_ovf_unused;

  assign clr_ovf_unused = clr_ovf;
  assign overflow       = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a simple transmitter model that records every started frame.
module tb_uart_tx_fifo;

`ifdef UART_TX_FIFO_OVF_EN
  localparam logic OvfExp = 1'b1;
`else
  localparam logic OvfExp = 1'b0;
`endif
  localparam int Frame = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ena = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_en = 1'b0;
  logic       clr_ovf = 1'b0;
  logic       tx_busy;
  logic       full, empty, overflow, tx_start;
  logic [4:0] count;
  logic [7:0] tx_data;

  int errors = 0;
  int checks = 0;

  // Transmitter model state
  logic [7:0] rx[$];
  logic [7:0] cur_byte;
  int         busy_cnt;
  int         starts = 0;
  int         hold_bad = 0;

  uart_tx_fifo #(.DEPTH_BITS(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .ena      (ena),
    .wr_data  (wr_data),
    .wr_en    (wr_en),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow),
    .clr_ovf  (clr_ovf),
    .tx_busy  (tx_busy),
    .tx_data  (tx_data),
    .tx_start (tx_start)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_busy  <= 1'b0;
      busy_cnt <= 0;
      cur_byte <= 8'h00;
    end else if (tx_busy) begin
      if (tx_data !== cur_byte) hold_bad <= hold_bad + 1;
      if (busy_cnt == 1) tx_busy <= 1'b0;
      busy_cnt <= busy_cnt - 1;
    end else if (tx_start) begin
      tx_busy  <= 1'b1;
      busy_cnt <= Frame;
      cur_byte <= tx_data;
      rx.push_back(tx_data);
      starts   <= starts + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int n);
    int k = 0;
    while (k < 2000 && !(rx.size() >= n && !tx_busy && empty && !tx_start)) begin
      tick(1);
      k++;
    end
    check("drain_done", 32'(k < 2000), 1);
    tick(2);
  endtask

  initial begin
    int base, sb, written, maxc, k;
    logic saw_empty;

    // Reset and idle
    tick(2);
    check("rst_tx_data", 32'(tx_data), 8'h00);
    check("rst_tx_start", 32'(tx_start), 0);
    check("rst_full", 32'(full), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_count", 32'(count), 0);
    check("rst_overflow", 32'(overflow), 0);
    rst = 1'b1;
    ena = 1'b1;
    k = 0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (tx_start !== 1'b0) k++;
    end
    check("idle_no_start", 32'(k), 0);

    // Single byte: start two cycles after the write
    wr_en = 1'b1; wr_data = 8'hA5;
    tick(1);
    wr_en = 1'b0;
    check("single_count1", 32'(count), 1);
    check("single_empty0", 32'(empty), 0);
    check("single_nostart", 32'(tx_start), 0);
    tick(1);
    check("single_start", 32'(tx_start), 1);
    check("single_data", 32'(tx_data), 8'hA5);
    check("single_empty1", 32'(empty), 1);
    wait_drain(1);
    check("single_rx_n", 32'(rx.size()), 1);
    check("single_rx", 32'(rx[0]), 8'hA5);
    check("single_starts", 32'(starts), 1);
    check("single_held", 32'(tx_data), 8'hA5);

    // Fill with ena low, 17th byte dropped
    ena = 1'b0;
    for (int i = 0; i < 17; i++) begin
      wr_en = 1'b1; wr_data = 8'(i);
      tick(1);
    end
    wr_en = 1'b0;
    check("fill_count", 32'(count), 16);
    check("fill_full", 32'(full), 1);
    check("fill_ovf", 32'(overflow), 32'(OvfExp));
    wr_en = 1'b1; clr_ovf = 1'b1; wr_data = 8'hEE;
    tick(1);
    wr_en = 1'b0;
    check("ovf_set_wins", 32'(overflow), 32'(OvfExp));
    check("ovf_drop_count", 32'(count), 16);
    tick(1);
    clr_ovf = 1'b0;
    check("ovf_cleared", 32'(overflow), 0);
    base = rx.size(); sb = starts;
    ena = 1'b1;
    wait_drain(base + 16);
    check("fill_rx_n", 32'(rx.size() - base), 16);
    k = 0;
    for (int i = 0; i < 16; i++) if (rx[base + i] !== 8'(i)) k++;
    check("fill_order", 32'(k), 0);
    check("fill_starts", 32'(starts - sb), 16);

    // Wrap-around stream, FIFO kept non-empty
    ena = 1'b0;
    base = rx.size();
    written = 0;
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h80 + written); written++;
      tick(1);
    end
    wr_en = 1'b0;
    ena = 1'b1;
    maxc = 0; saw_empty = 1'b0;
    for (int cyc = 0; cyc < 3000 && written < 40; cyc++) begin
      if (count < 5'd12) begin
        wr_en = 1'b1; wr_data = 8'(8'h80 + written); written++;
      end else begin
        wr_en = 1'b0;
      end
      tick(1);
      if (int'(count) > maxc) maxc = int'(count);
      if (empty) saw_empty = 1'b1;
    end
    wr_en = 1'b0;
    wait_drain(base + 40);
    check("wrap_rx_n", 32'(rx.size() - base), 40);
    k = 0;
    for (int i = 0; i < 40; i++) if (rx[base + i] !== 8'(8'h80 + i)) k++;
    check("wrap_order", 32'(k), 0);
    check("wrap_max_le16", 32'(maxc <= 16), 1);
    check("wrap_never_empty", 32'(saw_empty), 0);

    // Write plus pop at count=16: write dropped
    ena = 1'b0;
    base = rx.size();
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h40 + i);
      tick(1);
    end
    wr_en = 1'b0;
    check("full16_count", 32'(count), 16);
    clr_ovf = 1'b1;
    tick(1);
    clr_ovf = 1'b0;
    ena = 1'b1; wr_en = 1'b1; wr_data = 8'h99;
    tick(1);
    wr_en = 1'b0;
    check("full16_pop_count", 32'(count), 15);
    check("full16_ovf", 32'(overflow), 32'(OvfExp));
    check("full16_start", 32'(tx_start), 1);
    wait_drain(base + 16);
    k = 0;
    for (int i = 0; i < 16; i++) if (rx[base + i] !== 8'(8'h40 + i)) k++;
    check("full16_order", 32'(k), 0);
    check("full16_rx_n", 32'(rx.size() - base), 16);

    // Write plus pop at count=5: count unchanged
    ena = 1'b0;
    base = rx.size();
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h60 + i);
      tick(1);
    end
    ena = 1'b1; wr_en = 1'b1; wr_data = 8'h65;
    tick(1);
    wr_en = 1'b0;
    check("cnt5_count", 32'(count), 5);
    wait_drain(base + 6);
    k = 0;
    for (int i = 0; i < 6; i++) if (rx[base + i] !== 8'(8'h60 + i)) k++;
    check("cnt5_order", 32'(k), 0);

    // Reset asserted during SEND
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h11 * (i + 1));
      tick(1);
    end
    wr_en = 1'b0;
    k = 0;
    while (k < 50 && !tx_busy) begin
      tick(1);
      k++;
    end
    check("mid_busy_seen", 32'(k < 50), 1);
    tick(3);
    check("mid_count_before", 32'(count), 2);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_start", 32'(tx_start), 0);
    check("mid_rst_empty", 32'(empty), 1);
    check("mid_rst_count", 32'(count), 0);
    @(posedge clk);
    #1 rst = 1'b1;
    base = rx.size(); sb = starts;
    wr_en = 1'b1; wr_data = 8'h3C;
    tick(1);
    wr_en = 1'b0;
    tick(1);
    check("post_rst_start", 32'(tx_start), 1);
    check("post_rst_data", 32'(tx_data), 8'h3C);
    wait_drain(base + 1);
    check("post_rst_rx", 32'(rx[base]), 8'h3C);
    check("post_rst_starts", 32'(starts - sb), 1);

    check("tx_data_held", 32'(hold_bad), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Transmit-side buffer that sits directly upstream of the UART transmitter. Host logic pushes bytes into a 2^DEPTH_BITS-entry FIFO. The block pops one byte at a time, presents it on a held `tx_data` register and pulses `tx_start`. It then tracks the transmitter's `busy` flag so the next byte is only offered after the current frame, including stop bits, has completed.

## Interface
- `DEPTH_BITS`, default 4: log2 of FIFO depth (16 entries).
- `clk`  in  1: clock; all state changes on rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `ena`  in  1: pop enable; 0 blocks new frames from starting. Writes and the frame in flight are unaffected.
- `wr_data`  in  8: byte to enqueue.
- `wr_en`  in  1: enqueue strobe, one byte per cycle while high.
- `full`  out  1: FIFO holds 2^DEPTH_BITS entries.
- `empty`  out  1: FIFO holds 0 entries.
- `count`  out  DEPTH_BITS+1: current occupancy, 0..2^DEPTH_BITS.
- `overflow`  out  1: sticky flag, set when a write is dropped because the FIFO is full.
- `clr_ovf`  in  1: synchronous clear of `overflow`.
- `tx_busy`  in  1: transmitter busy flag.
- `tx_data`  out  8: byte being sent; registered.
- `tx_start`  out  1: start request to the transmitter.

## Operation
- Storage is a memory with rd_ptr and wr_ptr, each DEPTH_BITS wide and wrapping modulo 2^DEPTH_BITS, plus a `count` register. `full` and `empty` are decoded from `count`.
- Write: when wr_en=1 and full=0, mem[wr_ptr]<=wr_data, wr_ptr++ and count++.
- Write while full=1 (evaluated on pre-edge count): the byte is dropped and pointers are unchanged. This holds even if a pop occurs in the same cycle. `overflow` is set per Configuration.
- Simultaneous accepted write and pop: count is unchanged and both pointers advance.
- FSM has three states; reset state is IDLE.
  - IDLE: if ena=1, empty=0 and tx_busy=0, then tx_data<=mem[rd_ptr], rd_ptr++, count-- and go to START.
  - START: tx_start=1 (Moore output). If tx_busy=1, go to SEND.
  - SEND: tx_start=0. If tx_busy=0, go to IDLE.
- `tx_data` is held constant from the pop until the next pop. The transmitter derives parity combinationally from its data input throughout the frame, so `tx_data` must not change mid-frame.
- `tx_start` may be high for 2 cycles. The transmitter ignores start while running, so this is harmless.
- `ena` falling during START or SEND does not abort the frame. The FSM completes to IDLE and then stalls.
- `clr_ovf` and an overflow event in the same cycle: set wins, `overflow`=1.

## Timing
- Reset values: tx_data=8'h00, tx_start=0, full=0, empty=1, count=0, overflow=0, pointers=0, state=IDLE. Memory contents are not reset.
- Reset asserted mid-frame: the FIFO is emptied and tx_start drops immediately. Recovery of the transmitter itself is its owner's concern.
- Write-to-start latency with an idle transmitter is 2 cycles:
  - wr_en at cycle 0;
  - empty=0 at cycle 1, pop on the edge ending cycle 1;
  - tx_start=1 and new tx_data valid at cycle 2.
- Back-to-back frames: the next pop happens on the first IDLE cycle with tx_busy=0. The gap is 1 cycle after busy falls, then tx_start at +2.
- `count`, `full` and `empty` update on the edge following the write or pop.

## Configuration
- `UART_TX_FIFO_OVF_EN` defined: the `overflow` register, its set-on-drop behaviour and `clr_ovf` are implemented as described.
- `UART_TX_FIFO_OVF_EN` undefined: `overflow` is tied to 0 and `clr_ovf` is ignored. Writes to a full FIFO are still dropped silently.

## Test plan
- Reset then idle: outputs equal their reset values and tx_start stays 0 for 100 cycles.
- Single byte: write 8'hA5 with tx_busy modelled by a transmitter.
  - tx_start=1 two cycles after the write, with tx_data=8'hA5.
  - tx_data stays 8'hA5 until busy falls.
  - empty=1 after the pop.
- Fill and overflow: write 17 bytes 0x00..0x10 while ena=0.
  - count=16, full=1, overflow=1, and byte 0x10 is lost.
  - clr_ovf clears overflow.
  - With ena=1, bytes 0x00..0x0F are sent in order, with exactly one start per byte.
- Wrap-around: stream 40 bytes with the FIFO never emptying. Received order equals write order across pointer wrap, and count never exceeds 16.
- Simultaneous write and pop at count=16: the pop proceeds, the write is dropped, count=15 and overflow=1. Separately, at count=5 a write plus pop leaves count=5.
- Reset mid-frame during SEND: tx_start=0, empty=1 and count=0 asynchronously. After release, a new write 8'h3C starts correctly.
